// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared register-file writeback definitions and requester indices.
package rf_wb_arbiter_pkg;
    localparam int RF_DATA_WIDTH  = 32;
    localparam int RF_REG_NUM_BIT = 5;
    localparam int X0_IDX         = 0;
    localparam int WB_EXU         = 0;
    localparam int WB_LSU         = 1;
endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus encoded index.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    localparam logic [IW:0] N = (IW+1)'(NREQ);
    logic [IW:0] j;
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            j = (j >= N) ? j - N : j;
            if (!any && valid[j[IW-1:0]]) begin
                any               = 1'b1;
                grant[j[IW-1:0]]  = 1'b1;
                idx               = j[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port through one registered stage,
// which also serves as a forwarding source; x0 writes are consumed without reaching the file.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int REG_NUM_BIT = RF_REG_NUM_BIT,
    parameter int NREQ        = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*REG_NUM_BIT-1:0] req_waddr,
    input  logic [NREQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic                        flush,
    output logic                        rf_wen,
    output logic [REG_NUM_BIT-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    output logic [IW-1:0]               grant_id,
    output logic                        busy
);
    logic [NREQ-1:0]        grant;
    logic [IW-1:0]          gidx;
    logic                   any;
    logic                   accept;
    logic [REG_NUM_BIT-1:0] sel_waddr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   valid_d, valid_q;
    logic [REG_NUM_BIT-1:0] waddr_d, waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_d, wdata_q;
    logic [IW-1:0]          id_d, id_q;
    logic [IW-1:0]          ptr_d, ptr_q;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign accept    = any && !flush;
    assign req_ready = (rst || flush) ? '0 : grant;
    assign rf_wen    = valid_q && !rst;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign grant_id  = id_q;
    assign busy      = (|req_valid) || valid_q;

    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_waddr = req_waddr[i*REG_NUM_BIT +: REG_NUM_BIT];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d = sel_waddr != REG_NUM_BIT'(X0_IDX);
            waddr_d = sel_waddr;
            wdata_d = sel_wdata;
            id_d    = gidx;
            ptr_d   = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vectors with hand-computed expectations for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_waddr;
    logic [63:0] req_wdata;
    logic        flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        grant_id;
    logic        busy;
    int          n_chk = 0;
    int          n_err = 0;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .flush     (flush),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_waddr[i*5 +: 5]   = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 2'b11;
        req_waddr = '0;
        req_wdata = '0;
        #3;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_wen", 64'(rf_wen), 64'h0);
        check("rst_waddr", 64'(rf_waddr), 64'h0);
        check("rst_wdata", 64'(rf_wdata), 64'h0);
        check("rst_gid", 64'(grant_id), 64'h0);
        check("rst_busy", 64'(busy), 64'h1);
        req_valid = 2'b00;
        step();
        step();
        rst = 1'b0;

        drive(0, 1'b1, 5'd2, 32'h8000_0000);
        #1;
        check("single_ready", 64'(req_ready), 64'h1);
        step();
        drive(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("single_wen", 64'(rf_wen), 64'h1);
        check("single_waddr", 64'(rf_waddr), 64'h2);
        check("single_wdata", 64'(rf_wdata), 64'h8000_0000);
        check("single_gid", 64'(grant_id), 64'h0);
        step();
        check("single_idle_wen", 64'(rf_wen), 64'h0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 5'd10, 32'h100 + k);
            drive(1, 1'b1, 5'd11, 32'h200 + k);
            #1;
            check("cont_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k > 0) begin
                check("cont_wen", 64'(rf_wen), 64'h1);
                check("cont_gid", 64'(grant_id), 64'((k - 1) % 2));
                check("cont_waddr", 64'(rf_waddr), ((k - 1) % 2 == 0) ? 64'd10 : 64'd11);
                check("cont_wdata", 64'(rf_wdata), ((k - 1) % 2 == 0) ? 64'h100 + k - 1 : 64'h200 + k - 1);
            end
            step();
        end
        req_valid = 2'b00;
        #1;
        check("cont_last_gid", 64'(grant_id), 64'h1);
        check("cont_last_wdata", 64'(rf_wdata), 64'h203);

        drive(0, 1'b1, 5'd3, 32'h33);
        step();
        drive(0, 1'b0, 5'd0, 32'h0);
        drive(1, 1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_ready", 64'(req_ready), 64'h2);
        step();
        drive(1, 1'b0, 5'd0, 32'h0);
        #1;
        check("x0_wen", 64'(rf_wen), 64'h0);
        check("x0_busy", 64'(busy), 64'h0);
        req_valid = 2'b11;
        #1;
        check("x0_ptr_wrap", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        drive(0, 1'b1, 5'd4, 32'h44);
        #1;
        step();
        drive(0, 1'b1, 5'd7, 32'h77);
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(req_ready), 64'h0);
        check("flush_cur_wen", 64'(rf_wen), 64'h1);
        check("flush_cur_waddr", 64'(rf_waddr), 64'h4);
        step();
        flush = 1'b0;
        #1;
        check("flush_next_wen", 64'(rf_wen), 64'h0);
        check("flush_retry_ready", 64'(req_ready), 64'h1);
        step();
        drive(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("flush_retry_wen", 64'(rf_wen), 64'h1);
        check("flush_retry_waddr", 64'(rf_waddr), 64'h7);

        for (int k = 0; k < 8; k++) begin
            drive(1, 1'b1, 5'(k + 1), 32'h1000 + k);
            #1;
            check("stream_ready", 64'(req_ready), 64'h2);
            if (k > 0) begin
                check("stream_wen", 64'(rf_wen), 64'h1);
                check("stream_waddr", 64'(rf_waddr), 64'(k));
                check("stream_wdata", 64'(rf_wdata), 64'h1000 + k - 1);
            end
            step();
        end
        drive(1, 1'b0, 5'd0, 32'h0);
        #1;
        check("stream_last_wen", 64'(rf_wen), 64'h1);
        check("stream_last_waddr", 64'(rf_waddr), 64'h8);
        step();
        check("stream_done_wen", 64'(rf_wen), 64'h0);
        check("stream_done_busy", 64'(busy), 64'h0);

        drive(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("rstmid_ready", 64'(req_ready), 64'h1);
        step();
        drive(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rstmid_wen_pre", 64'(rf_wen), 64'h1);
        check("rstmid_wdata_pre", 64'(rf_wdata), 64'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check("rstmid_wen_async", 64'(rf_wen), 64'h0);
        check("rstmid_waddr_async", 64'(rf_waddr), 64'h0);
        step();
        rst = 1'b0;
        #1;
        check("rstmid_wen_post", 64'(rf_wen), 64'h0);
        req_valid = 2'b11;
        #1;
        check("rstmid_ptr0", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen/waddr/wdata) between NREQ writeback requesters, e.g. EXU result and LSU load data.
- Arbitration is round-robin with valid/ready handshakes and a registered write stage. That stage also drives the register-file write port and is exported as a forwarding source.
- Writes to x0 are consumed but never reach the register file.

Parameters:
- DATA_WIDTH, 32, width of write data
- REG_NUM_BIT, 5, register index width
- NREQ, 2, number of requesters (2..4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester accept; handshake when valid&ready
- req_waddr  in  NREQ*REG_NUM_BIT  packed; requester i at [i*REG_NUM_BIT +: REG_NUM_BIT]
- req_wdata  in  NREQ*DATA_WIDTH  packed, same indexing
- flush  in  1  cancels the stage-register write of the current cycle
- rf_wen  out  1  to register file write enable
- rf_waddr  out  REG_NUM_BIT  to register file
- rf_wdata  out  DATA_WIDTH  to register file
- grant_id  out  clog2(NREQ)  index of requester owning the stage register (valid when rf_wen)
- busy  out  1  any req_valid this cycle or stage register valid

Behaviour:
- Reset (async, rst=1):
  - stage valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0.
  - RR pointer = 0, so requester 0 has highest priority first.
  - req_ready is combinational and is 0 while rst=1.
- Arbitration (combinational, each cycle):
  - Search starts at index ptr, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready is one-hot (only the winner) or all zero.
  - No stall input: the port accepts one write per cycle; the stage is always overwritable.
- Accept at edge ending cycle t (a winner exists):
  - stage <= {waddr, wdata, id}.
  - stage valid <= (waddr != 0).
  - ptr <= (winner+1) mod NREQ.
  - No winner: stage valid <= 0, ptr unchanged.
- Latency:
  - rf_wen/rf_waddr/rf_wdata are driven from the stage register in cycle t+1.
  - The register file commits at the edge ending t+1.
  - Total 2 edges from handshake to architectural update; 1 write per cycle throughput.
- x0 handling: a request with waddr=0 handshakes normally and advances ptr, but rf_wen stays 0 in t+1.
- flush=1 in cycle t:
  - Stage valid forced to 0 at the next edge; no handshake occurs in cycle t (all req_ready=0).
  - The current rf_wen output in cycle t is unaffected.
  - ptr unchanged.
- rst asserted while the stage is valid: the write is dropped immediately (rf_wen falls asynchronously).
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles; no requester waits more than NREQ-1 grants.
- A requester must hold valid/waddr/wdata stable until its ready; deassertion before ready is legal (the request is simply withdrawn).
- NREQ is not a power of 2: the ptr wrap uses an explicit compare, never relying on overflow.

Decomposition:
- Shared package (npc common defs): REG_NUM_BIT and DATA_WIDTH defaults, the x0 index constant, and the requester index constants WB_EXU=0, WB_LSU=1.
- Natural sub-module: rr_arbiter. It is parameterised on NREQ, takes valid and ptr, and outputs one-hot grant and encoded index. It is purely combinational and reusable for future bus arbitration.
- The stage register, ptr update and flush logic stay in rf_wb_arbiter.

Test Plan:
1. Reset mid-write: handshake req0 with waddr=5, wdata=0xDEADBEEF; assert rst during t+1. Required: rf_wen drops to 0 at once; after release, ptr=0 and rf_wen=0.
2. Single requester: req0 with waddr=2, wdata=0x80000000 at cycle 3. Required: req_ready=01 in cycle 3; cycle 4 shows rf_wen=1, rf_waddr=2, rf_wdata=0x80000000, grant_id=0.
3. Contention: both valid for 4 cycles from reset. Required: grants 0,1,0,1; each handshake reflected one cycle later with the matching data.
4. x0 write: req1 with waddr=0, wdata=0x1234. Required: req_ready[1]=1 and ptr advances to 0; next cycle rf_wen=0.
5. Flush: req0 with waddr=7 valid and flush=1 in the same cycle. Required: req_ready=00; next cycle rf_wen=0; with flush=0 the following cycle, the request is accepted normally.
6. Back-to-back stream: req1 valid for 8 consecutive cycles with waddr=1..8 and req0 idle. Required: rf_waddr=1..8 appear on 8 consecutive cycles with no bubbles.
